neuron_mac_par: RTL
===================

NEURON_MAC_PAR -- requirements
Module: neuron_mac_par

Interface
REQ-001 LAYER_NO, 2, layer index matched against config_layer_num.
REQ-002 NEURON_NO, 0, neuron index matched against config_neuron_num.
REQ-003 NUM_WEIGHT, 30, weights per neuron; SHALL be a multiple of LANES.
REQ-004 DATA_WIDTH, 16, input/weight/output width, signed Q1.(DATA_WIDTH-1).
REQ-005 LANES, 2, parallel multiplier lanes per input beat.
REQ-006 ACT_TYPE, "relu", activation select, "relu" or "sigmoid".
REQ-007 SIGMOID_SIZE, 10, sigmoid ROM address width.
REQ-008 clk  in  1  sole clock; all logic on rising edge.
REQ-009 rst  in  1  synchronous, active-high reset.
REQ-010 myinput  in  LANES*DATA_WIDTH  packed inputs; lane i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-011 myinputValid  in  1  input beat valid.
REQ-012 in_ready  out  1  beat accepted when myinputValid & in_ready.
REQ-013 weightValid / biasValid  in  1 each  load strobes.
REQ-014 weightValue / biasValue  in  32 each  load data; low DATA_WIDTH bits used.
REQ-015 config_layer_num / config_neuron_num  in  32 each  load target.
REQ-016 out  out  DATA_WIDTH  activation result; outvalid  out  1  one-cycle result strobe.

Function
REQ-017 Weight load: on weightValid with both config fields matching, weight k SHALL be written to memory word k/LANES, lane k%LANES; k wraps NUM_WEIGHT-1 -> 0.
REQ-018 Bias load: on biasValid with match, bias register SHALL capture biasValue[DATA_WIDTH-1:0]; non-matching strobes SHALL be ignored.
REQ-019 FSM states IDLE, ACCUM, DRAIN, BIAS, ACT; in_ready=1 only in IDLE and ACCUM.
REQ-020 IDLE->ACCUM on first accepted beat; ACCUM->DRAIN on accepted beat NUM_WEIGHT/LANES; DRAIN (2 cycles)->BIAS->ACT->IDLE.
REQ-021 Beats MAY be non-consecutive; gaps SHALL not change results.
REQ-022 Products: signed DATA_WIDTH x DATA_WIDTH -> 2*DATA_WIDTH, registered one cycle after acceptance; lane products summed to one beat sum with saturation.
REQ-023 Accumulator 2*DATA_WIDTH signed; every add (beat sum, bias) SHALL saturate to 0x7FF..F / 0x800..0 on signed overflow.
REQ-024 Bias aligned as sign-extended bias << (DATA_WIDTH-1) before add.
REQ-025 ReLU: negative sum -> 0; else sum[2*DATA_WIDTH-2 -: DATA_WIDTH], saturating to 0x7FFF if any discarded upper magnitude bit set.
REQ-026 Sigmoid: ROM address sum[2*DATA_WIDTH-1 -: SIGMOID_SIZE], one-cycle ROM latency folded into ACT.
REQ-027 Latency: last beat accepted at cycle t -> outvalid=1 for exactly cycle t+5; out held until next result.
REQ-028 Accumulator and beat counter SHALL clear on entering IDLE; back-to-back vectors allowed from the cycle after outvalid.
REQ-029 Weight/bias loads concurrent with accumulation SHALL be accepted; result using a word being rewritten is undefined.

Reset
REQ-030 rst SHALL force IDLE, accumulator 0, beat counter 0, write index 0, bias 0, out 0, outvalid 0, in_ready 1.
REQ-031 rst mid-vector SHALL abort with no outvalid; weight memory contents retained.

Structure
REQ-032 Shared package fnn_pkg: FSM state enum, activation-type constants, saturation limit helpers.
REQ-033 One sub-module neuron_wmem: single write/read port memory, LANES*DATA_WIDTH wide, NUM_WEIGHT/LANES deep, registered read; existing Sig_ROM reused for sigmoid.

Verification (LANES=2, NUM_WEIGHT=4, DATA_WIDTH=16, relu unless stated)
REQ-034 Weights 0x4000 x4, bias 0, two beats of {0x2000,0x2000} -> out 0x4000, outvalid 5 cycles after second beat.
REQ-035 Same plus bias 0x4000 -> sum 0x40000000 -> out 0x7FFF (output saturation).
REQ-036 Weights 0x7FFF, inputs 0x7FFF -> accumulator clamps 0x7FFFFFFF, out 0x7FFF; inputs 0xE000 with weights 0x4000 -> out 0x0000.
REQ-037 weightValid with config_neuron_num != NEURON_NO -> memory unchanged, prior result repeats bit-exact.
REQ-038 rst asserted after first beat -> no outvalid; fresh vector afterwards gives REQ-034 result.
REQ-039 Beats separated by 3 idle cycles and back-to-back vectors -> identical results, one outvalid per vector.

Source files
------------

// File: rtl/fnn_pkg.sv
// Shared definitions for the feed-forward neuron blocks: FSM states,
// activation selectors and signed saturation helpers.
package fnn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_DRAIN,
        ST_BIAS,
        ST_ACT
    } state_e;

    localparam string ACT_RELU    = "relu";
    localparam string ACT_SIGMOID = "sigmoid";

    // Largest / smallest value of a w-bit two's-complement number, in 64 bits.
    function automatic logic signed [63:0] sat_max(input int unsigned w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int unsigned w);
        return -(64'sd1 <<< (w - 1));
    endfunction

    function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                     input int unsigned w);
        if (v > sat_max(w)) begin
            return sat_max(w);
        end
        if (v < sat_min(w)) begin
            return sat_min(w);
        end
        return v;
    endfunction

endpackage

// File: rtl/Sig_ROM.sv
// Sigmoid lookup with registered output. Address is the top bits of a Q2.x
// sum; contents follow the linear-clamped approximation 0.5 + x/4.
module Sig_ROM #(
    parameter int IN_WIDTH   = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic [IN_WIDTH-1:0]   x,
    output logic [DATA_WIDTH-1:0] out
);

    function automatic logic [DATA_WIDTH-1:0] sig_entry(input logic [IN_WIDTH-1:0] a);
        logic signed [63:0] v;
        v = (64'($signed(a)) <<< (DATA_WIDTH - 1)) >>> IN_WIDTH;
        v = v + (64'sd1 <<< (DATA_WIDTH - 2));
        if (v < 64'sd0) begin
            v = 64'sd0;
        end
        if (v > (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1) begin
            v = (64'sd1 <<< (DATA_WIDTH - 1)) - 64'sd1;
        end
        return DATA_WIDTH'(v);
    endfunction

    always_ff @(posedge clk) begin
        out <= sig_entry(x);
    end

endmodule

// File: rtl/neuron_wmem.sv
// Weight store: one lane-granular write port, one registered read port,
// each word holding one input beat worth of weights.
module neuron_wmem #(
    parameter int DATA_WIDTH = 16,
    parameter int LANES      = 2,
    parameter int DEPTH      = 15
) (
    input  logic                                      clk,
    input  logic                                      we_i,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] waddr_i,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] wlane_i,
    input  logic [DATA_WIDTH-1:0]                     wdata_i,
    input  logic                                      re_i,
    input  logic [((DEPTH > 1) ? $clog2(DEPTH) : 1)-1:0] raddr_i,
    output logic [LANES*DATA_WIDTH-1:0]               rdata_o
);

    logic [LANES*DATA_WIDTH-1:0] mem [DEPTH];
    logic [LANES*DATA_WIDTH-1:0] rdata_q;

    // NOTE: storage arrays and read data carry no reset; weights must survive
    // a reset of the control path, and nothing downstream trusts rdata_q
    // until a valid bit that is reset says so.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i][wlane_i*DATA_WIDTH +: DATA_WIDTH] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/neuron_mac_par.sv
// Multi-lane multiply-accumulate neuron: weighted sum of streamed input beats,
// bias add and activation, every add saturating.
module neuron_mac_par
    import fnn_pkg::*;
#(
    parameter int    LAYER_NO     = 2,
    parameter int    NEURON_NO    = 0,
    parameter int    NUM_WEIGHT   = 30,
    parameter int    DATA_WIDTH   = 16,
    parameter int    LANES        = 2,
    parameter string ACT_TYPE     = "relu",
    parameter int    SIGMOID_SIZE = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [LANES*DATA_WIDTH-1:0] myinput,
    input  logic                        myinputValid,
    output logic                        in_ready,
    input  logic                        weightValid,
    input  logic                        biasValid,
    input  logic [31:0]                 weightValue,
    input  logic [31:0]                 biasValue,
    input  logic [31:0]                 config_layer_num,
    input  logic [31:0]                 config_neuron_num,
    output logic [DATA_WIDTH-1:0]       out,
    output logic                        outvalid
);

    localparam int ACC_W = 2 * DATA_WIDTH;
    localparam int NB    = NUM_WEIGHT / LANES;
    localparam int AW    = (NB > 1) ? $clog2(NB) : 1;
    localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int IW    = LANES * DATA_WIDTH;
    localparam bit IS_SIGMOID = (ACT_TYPE == ACT_SIGMOID);

    state_e                   state_q, state_d;
    logic                     drain_q, drain_d;
    logic [AW-1:0]            beat_q, beat_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic [AW-1:0]            wr_word_q, wr_word_d;
    logic [LW-1:0]            wr_lane_q, wr_lane_d;
    logic signed [DATA_WIDTH-1:0] bias_q, bias_d;
    logic [DATA_WIDTH-1:0]    out_q, out_d;
    logic                     outvalid_q, outvalid_d;

    logic                     s1_vld_q, s2_vld_q;
    logic [IW-1:0]            in_q;
    logic [IW-1:0]            w_rd;
    logic signed [ACC_W-1:0]  prod_q [LANES];
    logic signed [ACC_W-1:0]  prod_d [LANES];

    logic                     accept, last_beat, wt_hit, bias_hit;
    logic signed [ACC_W-1:0]  beat_sum, acc_beat, acc_bias;
    logic signed [63:0]       beat_wide;
    logic [DATA_WIDTH-1:0]    relu_val, rom_out;
    logic [SIGMOID_SIZE-1:0]  rom_addr;

    assign in_ready  = (state_q == ST_IDLE) || (state_q == ST_ACCUM);
    assign accept    = myinputValid && in_ready;
    assign last_beat = (beat_q == AW'(NB - 1));
    assign wt_hit    = weightValid && (config_layer_num == 32'(LAYER_NO))
                                   && (config_neuron_num == 32'(NEURON_NO));
    assign bias_hit  = biasValid && (config_layer_num == 32'(LAYER_NO))
                                 && (config_neuron_num == 32'(NEURON_NO));

    neuron_wmem #(
        .DATA_WIDTH (DATA_WIDTH),
        .LANES      (LANES),
        .DEPTH      (NB)
    ) u_wmem (
        .clk     (clk),
        .we_i    (wt_hit),
        .waddr_i (wr_word_q),
        .wlane_i (wr_lane_q),
        .wdata_i (weightValue[DATA_WIDTH-1:0]),
        .re_i    (accept),
        .raddr_i (beat_q),
        .rdata_o (w_rd)
    );

    function automatic logic signed [ACC_W-1:0] lane_mul(input logic signed [DATA_WIDTH-1:0] a,
                                                         input logic signed [DATA_WIDTH-1:0] b);
        return ACC_W'(a) * ACC_W'(b);
    endfunction

    // NOTE: combinational blocks use blocking '=' so later statements see
    // earlier results; every clocked register below uses '<=' only.
    always_comb begin
        for (int i = 0; i < LANES; i++) begin
            prod_d[i] = lane_mul(in_q[i*DATA_WIDTH +: DATA_WIDTH],
                                 w_rd[i*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    always_comb begin
        beat_wide = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_wide = beat_wide + 64'(prod_q[i]);
        end
        beat_sum = ACC_W'(sat_clamp(beat_wide, ACC_W));
        acc_beat = ACC_W'(sat_clamp(64'(acc_q) + 64'(beat_sum), ACC_W));
        acc_bias = ACC_W'(sat_clamp(64'(acc_q) + (64'(bias_q) <<< (DATA_WIDTH - 1)), ACC_W));
    end

    // Q2.(2W-2) sum to Q1.(W-1): the bit just below the sign must be clear to fit.
    always_comb begin
        if (acc_q[ACC_W-1]) begin
            relu_val = '0;
        end else if (acc_q[ACC_W-2]) begin
            relu_val = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else begin
            relu_val = acc_q[ACC_W-2 -: DATA_WIDTH];
        end
    end

    // The ROM is addressed from the biased sum during BIAS so its one-cycle
    // latency lands in ACT alongside the ReLU path.
    assign rom_addr = acc_bias[ACC_W-1 -: SIGMOID_SIZE];

    if (IS_SIGMOID) begin : g_sigmoid
        Sig_ROM #(
            .IN_WIDTH   (SIGMOID_SIZE),
            .DATA_WIDTH (DATA_WIDTH)
        ) u_sig_rom (
            .clk (clk),
            .x   (rom_addr),
            .out (rom_out)
        );
    end else begin : g_relu
        logic unused_rom_addr;
        assign unused_rom_addr = ^rom_addr;
        assign rom_out = '0;
    end

    logic unused_hi_bits;
    assign unused_hi_bits = ^{weightValue[31:DATA_WIDTH], biasValue[31:DATA_WIDTH]};

    // NOTE: every variable gets its hold value first, so no branch of the
    // case can leave one unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        drain_d    = drain_q;
        beat_d     = beat_q;
        acc_d      = acc_q;
        out_d      = out_q;
        outvalid_d = 1'b0;

        if (s2_vld_q) begin
            acc_d = acc_beat;
        end

        unique case (state_q)
            ST_IDLE, ST_ACCUM: begin
                if (accept) begin
                    drain_d = 1'b0;
                    if (last_beat) begin
                        beat_d  = '0;
                        state_d = ST_DRAIN;
                    end else begin
                        beat_d  = beat_q + AW'(1);
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_DRAIN: begin
                drain_d = ~drain_q;
                if (drain_q) begin
                    state_d = ST_BIAS;
                end
            end
            ST_BIAS: begin
                acc_d   = acc_bias;
                state_d = ST_ACT;
            end
            ST_ACT: begin
                out_d      = IS_SIGMOID ? rom_out : relu_val;
                outvalid_d = 1'b1;
                acc_d      = '0;
                beat_d     = '0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        wr_word_d = wr_word_q;
        wr_lane_d = wr_lane_q;
        bias_d    = bias_q;
        if (wt_hit) begin
            if (wr_lane_q == LW'(LANES - 1)) begin
                wr_lane_d = '0;
                wr_word_d = (wr_word_q == AW'(NB - 1)) ? '0 : wr_word_q + AW'(1);
            end else begin
                wr_lane_d = wr_lane_q + LW'(1);
            end
        end
        if (bias_hit) begin
            bias_d = biasValue[DATA_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            drain_q    <= 1'b0;
            beat_q     <= '0;
            acc_q      <= '0;
            wr_word_q  <= '0;
            wr_lane_q  <= '0;
            bias_q     <= '0;
            out_q      <= '0;
            outvalid_q <= 1'b0;
            s1_vld_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            drain_q    <= drain_d;
            beat_q     <= beat_d;
            acc_q      <= acc_d;
            wr_word_q  <= wr_word_d;
            wr_lane_q  <= wr_lane_d;
            bias_q     <= bias_d;
            out_q      <= out_d;
            outvalid_q <= outvalid_d;
            s1_vld_q   <= accept;
            s2_vld_q   <= s1_vld_q;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            in_q <= myinput;
        end
        if (s1_vld_q) begin
            prod_q <= prod_d;
        end
    end

    assign out      = out_q;
    assign outvalid = outvalid_q;

endmodule
